// File: rtl/div_radix2.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU.
// Produces one quotient bit per cycle and returns {remainder, quotient}.
module div_radix2 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_rem;
  logic             r_signed;
  logic             r_sign_q;
  logic             r_sign_r;

  logic [WIDTH-1:0] w_abs1;
  logic [WIDTH-1:0] w_abs2;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic             w_last;

  // Negating 0x80..0 yields 0x80..0, which is the correct unsigned magnitude.
  assign w_abs1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // Extra top bit of the difference acts as the borrow of the trial subtract.
  assign w_rem_sh = {r_rem, r_dividend[WIDTH-1]};
  assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_divisor};
  assign w_ge     = ~w_diff[WIDTH+1];
  assign w_rem_nx = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_nx = {r_dividend[WIDTH-2:0], w_ge};

  assign w_quo_fix = (r_signed && r_sign_q) ? -w_quo_nx : w_quo_nx;
  assign w_rem_fix = (r_signed && r_sign_r) ? -w_rem_nx : w_rem_nx;
  assign w_last    = (r_cnt == CNT_W'(WIDTH-1));

  assign busy_o = (r_state == S_DIVZERO) || (r_state == S_ON);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_signed   <= 1'b0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      result_o   <= '0;
      ready_o    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              r_state <= S_DIVZERO;
            end else begin
              r_dividend <= w_abs1;
              r_divisor  <= w_abs2;
              r_signed   <= signed_div_i;
              r_sign_q   <= opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1];
              r_sign_r   <= opdata1_i[WIDTH-1];
              r_rem      <= '0;
              r_cnt      <= '0;
              r_state    <= S_ON;
            end
          end
        end
        S_DIVZERO: begin
          if (annul_i) begin
            r_state <= S_IDLE;
          end else begin
            result_o <= '0;
            ready_o  <= 1'b1;
            r_state  <= S_END;
          end
        end
        S_ON: begin
          if (annul_i) begin
            r_state  <= S_IDLE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else begin
            r_rem      <= w_rem_nx;
            r_dividend <= w_quo_nx;
            r_cnt      <= r_cnt + CNT_W'(1);
            if (w_last) begin
              result_o <= {w_rem_fix, w_quo_fix};
              ready_o  <= 1'b1;
              r_state  <= S_END;
            end
          end
        end
        S_END: begin
          if (!start_i || annul_i) begin
            r_state  <= S_IDLE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: directed vectors, corner sequences
// and random operands against an arithmetic reference model.
module tb_div_radix2;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          signed_div_i;
  logic [W-1:0]  opdata1_i;
  logic [W-1:0]  opdata2_i;
  logic          start_i;
  logic          annul_i;
  logic [2*W-1:0] result_o;
  logic          ready_o;
  logic          busy_o;

  int checks;
  int failures;

  div_radix2 #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sgn;
    logic [2*W-1:0] exp_res;
    int             exp_lat;
    int             exp_busy;
  } vec_t;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with truncation toward zero.
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    longint sa, sb, q, r;
    logic [W-1:0] q32, r32;
    if (b == '0) return '0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    q32 = q[W-1:0];
    r32 = r[W-1:0];
    return {r32, q32};
  endfunction

  // Runs one division with start held; returns result, latency and busy cycles.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         output logic [2*W-1:0] res, output int lat, output int busy_cnt,
                         output logic held_ok);
    logic [2*W-1:0] first;
    @(negedge clk);
    opdata1_i = a; opdata2_i = b; signed_div_i = sgn; start_i = 1'b1;
    lat = 0; busy_cnt = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (busy_o) busy_cnt++;
      opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = $urandom_range(0, 1);
    end while (!ready_o && lat < 80);
    res = result_o;
    first = result_o;
    @(posedge clk); @(negedge clk);
    held_ok = ready_o && (result_o == first);
    start_i = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  vec_t           vecs[$];
  logic [2*W-1:0] res;
  int             lat, bc;
  logic           held;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    #12;
    chk("reset_result", result_o, '0);
    chk("reset_ready", {63'd0, ready_o}, '0);
    chk("reset_busy", {63'd0, busy_o}, '0);
    @(negedge clk); rst = 1'b1;

    vecs.push_back('{32'd100,        32'd7,          1'b0, 64'h00000002_0000000E, 33, 32});
    vecs.push_back('{32'hFFFFFFF9,   32'h00000002,   1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 32});
    vecs.push_back('{32'h00000007,   32'hFFFFFFFE,   1'b1, 64'h00000001_FFFFFFFD, 33, 32});
    vecs.push_back('{32'h80000000,   32'hFFFFFFFF,   1'b1, 64'h00000000_80000000, 33, 32});
    vecs.push_back('{32'h80000000,   32'hFFFFFFFF,   1'b0, 64'h80000000_00000000, 33, 32});
    vecs.push_back('{32'h12345678,   32'h00000000,   1'b0, 64'h0,                 2,  1});
    vecs.push_back('{32'hDEADBEEF,   32'h00000000,   1'b1, 64'h0,                 2,  1});
    vecs.push_back('{32'h80000000,   32'h00000002,   1'b1, 64'h00000000_C0000000, 33, 32});

    for (int i = 0; i < vecs.size(); i++) begin
      run_div(vecs[i].a, vecs[i].b, vecs[i].sgn, res, lat, bc, held);
      $display("vec %0d: a=0x%08h b=0x%08h s=%0d res=0x%016h lat=%0d busy=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].sgn, res, lat, bc);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_busy", i), 64'(bc), 64'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_hold", i), {63'd0, held}, 64'd1);
      chk($sformatf("vec%0d_drop_ready", i), {63'd0, ready_o}, '0);
      chk($sformatf("vec%0d_drop_result", i), result_o, '0);
    end

    // Annul at iteration 10: abort with no result, then a fresh division.
    begin
      logic seen_ready;
      seen_ready = 1'b0;
      @(negedge clk);
      opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
      for (int k = 0; k < 11; k++) begin
        @(posedge clk); @(negedge clk);
        if (ready_o) seen_ready = 1'b1;
      end
      annul_i = 1'b1;
      @(posedge clk); @(negedge clk);
      annul_i = 1'b0; start_i = 1'b0;
      $display("annul: ready=%0d busy=%0d res=0x%016h", ready_o, busy_o, result_o);
      chk("annul_busy", {63'd0, busy_o}, '0);
      chk("annul_result", result_o, '0);
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); @(negedge clk);
        if (ready_o) seen_ready = 1'b1;
      end
      chk("annul_no_ready", {63'd0, seen_ready}, '0);
      run_div(32'd9, 32'd3, 1'b0, res, lat, bc, held);
      $display("after annul 9/3: res=0x%016h lat=%0d", res, lat);
      chk("after_annul_result", res, 64'h00000000_00000003);
    end

    // Asynchronous reset in the middle of a division.
    @(negedge clk);
    opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
    for (int k = 0; k < 21; k++) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    $display("async reset: ready=%0d busy=%0d res=0x%016h", ready_o, busy_o, result_o);
    chk("arst_ready", {63'd0, ready_o}, '0);
    chk("arst_busy", {63'd0, busy_o}, '0);
    chk("arst_result", result_o, '0);
    @(negedge clk); start_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, res, lat, bc, held);
    $display("after reset FFFFFFFF/1: res=0x%016h lat=%0d", res, lat);
    chk("arst_after_result", res, 64'h00000000_FFFFFFFF);

    // Random operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      logic s;
      int lat_exp;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = W'($urandom_range(0, 15));
        1: b = $urandom >> $urandom_range(0, 31);
        2: b = -W'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      s = $urandom_range(0, 1);
      lat_exp = (b == '0) ? 2 : 33;
      run_div(a, b, s, res, lat, bc, held);
      $display("rnd %0d: a=0x%08h b=0x%08h s=%0d res=0x%016h lat=%0d", i, a, b, s, res, lat);
      chk($sformatf("rnd%0d_result", i), res, ref_div(a, b, s));
      chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(lat_exp));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_radix2.md
Name: div_radix2

Overview:
- Multi-cycle restoring radix-2 integer divider for DIV/DIVU, one quotient bit per cycle.
- Sits directly downstream of the execute-stage ALU. The ALU registers the operands and drives start; it stalls the pipeline while start is high.
- The divider returns {remainder, quotient}, which the ALU forwards to the HI/LO write path.
- The ALU clocks this block on the inverted core clock; the block itself sees a single clock domain.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  block clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with the operands.
- opdata1_i  input  WIDTH  dividend.
- opdata2_i  input  WIDTH  divisor.
- start_i  input  1  request; held high by the ALU until ready_o is seen.
- annul_i  input  1  cancel; asserted on an exception in a later stage.
- result_o  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}, i.e. {HI, LO}.
- ready_o  output  1  result valid.
- busy_o  output  1  high in DIVZERO or ON.

Behaviour:
- Reset (rst=0, async): state=IDLE, result_o=0, ready_o=0, counter=0, internal dividend/divisor/partial-remainder regs=0. Reset mid-division aborts with no result.
- States: IDLE, DIVZERO, ON, END. Outputs ready_o and result_o are registered. busy_o is decoded from state.
- IDLE, start_i=1 and annul_i=0:
  - divisor==0 -> DIVZERO.
  - Otherwise latch the operands. If signed_div_i=1, latch |dividend| and |divisor| (two's complement of negative values) and record sign_q = sign(op1)^sign(op2) and sign_r = sign(op1). Clear the counter, partial remainder=0, then go to ON.
- IDLE, start_i=1 and annul_i=1: stay in IDLE.
- Operands and signed_div_i are ignored outside the IDLE sampling edge.
- DIVZERO: next edge -> END with result_o=0. Divide-by-zero is defined to return HI=0, LO=0.
- ON, each edge:
  - Shift {rem, dividend} left by 1. Trial-subtract the divisor in WIDTH+1 bits. If non-negative, keep the difference and set quotient LSB=1; else restore and set LSB=0.
  - Increment the counter.
  - On the edge where the counter==WIDTH-1 step completes: apply sign correction (negate the quotient if sign_q, negate the remainder if sign_r, signed mode only), load result_o, set ready_o=1, go to END.
- ON, annul_i=1: takes priority over the iteration. Next edge -> IDLE, ready_o=0, result_o=0, no partial result exposed.
- Latency, normal case: start sampled at edge 0 → ON; edges 1..WIDTH perform iterations; ready_o high after edge WIDTH (33 edges total for WIDTH=32).
- Latency, divide-by-zero: ready_o high after edge 1.
- END:
  - ready_o=1 and result_o held stable while start_i=1 and annul_i=0.
  - start_i=0 or annul_i=1 -> IDLE, ready_o=0, result_o=0.
  - A new division requires at least one IDLE cycle.
- Arithmetic:
  - Quotient truncates toward zero. The remainder has the dividend's sign (MIPS semantics).
  - Signed 0x80000000 / 0xFFFFFFFF wraps: Q=0x80000000, R=0. No overflow flag.
  - Absolute value of 0x80000000 is taken as unsigned 0x80000000; this must be handled correctly.
- start_i dropping during ON without annul_i: the division completes. END then exits on the next edge because start_i=0.

Test Plan:
- Unsigned 100/7, start held → ready_o rises exactly 33 edges after start sampled, result_o=0x00000002_0000000E; start low → ready_o=0 next edge.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) → result_o=0xFFFFFFFF_FFFFFFFD. Signed 7/-2 → 0x00000001_FFFFFFFD.
- 0x80000000 / 0xFFFFFFFF: signed → 0x00000000_80000000; unsigned → 0x80000000_00000000.
- Divisor 0, either mode → ready_o after 2 edges, result_o=0, busy_o high for exactly 1 cycle.
- annul_i pulsed at iteration 10 → IDLE next edge, ready_o never asserts, result_o=0. A following 9/3 start → 0x00000000_00000003.
- rst low asynchronously at iteration 20 (mid-clock) → ready_o/result_o/busy_o go 0 immediately. After release, 0xFFFFFFFF/1 unsigned → 0x00000000_FFFFFFFF.
